dot_scan_rx: RTL and testbench
==============================

DOT_SCAN_RX -- requirements
Module: dot_scan_rx

Interface
REQ-001 Parameter ROW_W, default 14, bits per dot column word.
REQ-002 Parameter COLS, default 10, number of scanned columns per frame.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
REQ-005 dot_d  input  ROW_W  dot row data from the column scanner, sampled every clk.
REQ-006 dot_scan  input  COLS  active-low one-hot column select; bit k low selects column k.
REQ-007 rd_col  input  4  column index for the frame read port.
REQ-008 rd_data  output  ROW_W  combinational read of committed frame column rd_col; 0 when rd_col >= COLS.
REQ-009 frame_valid  output  1  one-cycle pulse when a complete frame is committed.
REQ-010 scan_err  output  1  one-cycle pulse on a scan sequence violation.
REQ-011 frame_cnt  output  8  count of committed frames, wraps 255->0.
REQ-012 err_cnt  output  8  count of scan errors, saturates at 255.
REQ-013 locked  output  1  high while the FSM is in CAPTURE.

Function
REQ-014 Each cycle, dot_scan SHALL be decoded as valid only if exactly one bit is 0; the decoded index is col_idx.
REQ-015 The FSM SHALL have states SYNC and CAPTURE; the reset state is SYNC.
REQ-016 SYNC: a valid col_idx==0 writes dot_d to shadow[0], sets exp_col=1, goes to CAPTURE; any other input is ignored without an error.
REQ-017 CAPTURE: a valid col_idx==exp_col writes dot_d to shadow[col_idx] and increments exp_col.
REQ-018 CAPTURE with col_idx==COLS-1 accepted: shadow plus the current dot_d SHALL be copied to the committed frame in the same edge; frame_valid high the next cycle; frame_cnt increments; exp_col=0; remain in CAPTURE.
REQ-019 CAPTURE with invalid pattern (all-ones, multiple zeros) or wrong col_idx: scan_err pulses next cycle, err_cnt increments (saturating), shadow discarded.
REQ-020 Error with valid col_idx==0: shadow[0] written, exp_col=1, stay in CAPTURE (resynchronised restart); otherwise go to SYNC.
REQ-021 Committed frame SHALL change only on commit; rd_data is stable between commits.
REQ-022 frame_valid and scan_err SHALL never both assert in one cycle.
REQ-023 Latency: last column sampled at edge N -> rd_data reflects the new frame and frame_valid=1 after edge N; frame_valid falls after edge N+1.
REQ-024 A repeated column (col_idx==exp_col-1) SHALL be treated as an error (scanner advances every cycle).

Reset
REQ-025 On reset=0: state SYNC, exp_col=0, shadow and committed frame all 0, frame_valid=0, scan_err=0, frame_cnt=0, err_cnt=0, locked=0.
REQ-026 Reset asserted mid-frame SHALL discard partial data; after release a new frame starts only at a column-0 pattern.

Structure
REQ-027 ROW_W, COLS, state encoding (SYNC, CAPTURE) and the column-0 scan pattern constant SHALL reside in the shared taximeter display package.
REQ-028 One sub-module, scan_onehot_dec (COLS-wide active-low one-hot to index plus valid flag), SHALL be instantiated.

Verification
REQ-029 Reset, then 10 cycles of dot_scan walking 11111_11110..01111_11111 with dot_d=column index -> frame_valid pulse 1 cycle after the 10th sample; rd_col=7 gives rd_data=7; frame_cnt=1.
REQ-030 Start the stream at column 5 -> no commit and no scan_err until column 0 is seen; first full frame commits after 10 further cycles.
REQ-031 Inject dot_scan=11111_11111 at column 4 of frame 2 -> scan_err pulse, err_cnt=1, locked=0, rd_data still holds frame 1.
REQ-032 Inject column 0 in place of column 6 -> scan_err pulse, locked stays 1, commit 10 cycles after the injected column 0.
REQ-033 Run 256 clean frames -> frame_cnt wraps to 0; 300 forced errors -> err_cnt holds 255.
REQ-034 Pull reset low at column 3 and release -> all outputs 0; next commit only after a full 0..9 sequence.

Source files
------------

// File: rtl/dot_scan_rx_pkg.sv
// dot_scan_rx_pkg: shared taximeter display constants for the dot column scan receiver
package dot_scan_rx_pkg;
    localparam int DOT_ROW_W = 14;
    localparam int DOT_COLS = 10;
    localparam int COL_IW = 4;
    localparam logic [0:0] ST_SYNC = 1'b0;
    localparam logic [0:0] ST_CAPTURE = 1'b1;
    localparam logic [DOT_COLS-1:0] COL0_PAT = {{(DOT_COLS-1){1'b1}}, 1'b0};
endpackage

// File: rtl/dot_scan_rx_scan_onehot_dec.sv
// scan_onehot_dec: active-low one-hot column select to column index plus valid flag
module scan_onehot_dec #(
    parameter int N = 10,
    parameter int IW = 4
) (
    input  logic [N-1:0]  scan_n_i,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);
    logic seen;
    logic multi;
    // find the low bit and flag any second low bit as an invalid pattern
    always_comb begin
        seen = 1'b0;
        multi = 1'b0;
        idx_o = '0;
        for (int k = 0; k < N; k++) begin
            if (!scan_n_i[k]) begin
                multi = multi | seen;
                seen = 1'b1;
                idx_o = IW'(k);
            end
        end
        valid_o = seen & ~multi;
    end
endmodule

// File: rtl/dot_scan_rx.sv
// dot_scan_rx: captures scanned dot columns into a shadow frame and commits complete frames
module dot_scan_rx
    import dot_scan_rx_pkg::*;
#(
    parameter int ROW_W = DOT_ROW_W,
    parameter int COLS = DOT_COLS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ROW_W-1:0] dot_d,
    input  logic [COLS-1:0]  dot_scan,
    input  logic [3:0]       rd_col,
    output logic [ROW_W-1:0] rd_data,
    output logic             frame_valid,
    output logic             scan_err,
    output logic [7:0]       frame_cnt,
    output logic [7:0]       err_cnt,
    output logic             locked
);
    localparam logic [COL_IW-1:0] LAST = COL_IW'(COLS - 1);

    logic [COL_IW-1:0]           col_idx;
    logic                        col_vld;
    logic [0:0]                  state_q, state_d;
    logic [COL_IW-1:0]           exp_q, exp_d;
    logic [COLS-1:0][ROW_W-1:0]  shadow_q, shadow_d;
    logic [COLS-1:0][ROW_W-1:0]  frame_q, frame_d;
    logic                        fv_q, fv_d;
    logic                        err_q, err_d;
    logic [7:0]                  fcnt_q, fcnt_d;
    logic [7:0]                  ecnt_q, ecnt_d;

    scan_onehot_dec #(.N(COLS), .IW(COL_IW)) u_dec (
        .scan_n_i (dot_scan),
        .idx_o    (col_idx),
        .valid_o  (col_vld)
    );

    // next-state: lock on column 0, accept columns in order, commit on the last, resync on errors
    always_comb begin
        state_d = state_q;
        exp_d = exp_q;
        shadow_d = shadow_q;
        frame_d = frame_q;
        fv_d = 1'b0;
        err_d = 1'b0;
        fcnt_d = fcnt_q;
        ecnt_d = ecnt_q;
        if (state_q == ST_SYNC) begin
            if (col_vld && col_idx == '0) begin
                shadow_d[0] = dot_d;
                exp_d = COL_IW'(1);
                state_d = ST_CAPTURE;
            end
        end else if (col_vld && col_idx == exp_q) begin
            shadow_d[col_idx] = dot_d;
            if (col_idx == LAST) begin
                frame_d = shadow_d;
                fv_d = 1'b1;
                fcnt_d = fcnt_q + 8'd1;
                exp_d = '0;
            end else begin
                exp_d = exp_q + COL_IW'(1);
            end
        end else begin
            err_d = 1'b1;
            ecnt_d = (ecnt_q == 8'hFF) ? ecnt_q : ecnt_q + 8'd1;
            shadow_d = '0;
            if (col_vld && col_idx == '0) begin
                shadow_d[0] = dot_d;
                exp_d = COL_IW'(1);
            end else begin
                exp_d = '0;
                state_d = ST_SYNC;
            end
        end
    end

    // state registers, cleared immediately by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SYNC;
            exp_q <= '0;
            shadow_q <= '0;
            frame_q <= '0;
            fv_q <= 1'b0;
            err_q <= 1'b0;
            fcnt_q <= '0;
            ecnt_q <= '0;
        end else begin
            state_q <= state_d;
            exp_q <= exp_d;
            shadow_q <= shadow_d;
            frame_q <= frame_d;
            fv_q <= fv_d;
            err_q <= err_d;
            fcnt_q <= fcnt_d;
            ecnt_q <= ecnt_d;
        end
    end

    // read port: committed column, zero beyond the last column
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < COLS; k++) begin
            if (rd_col == 4'(k)) rd_data = frame_q[k];
        end
    end

    assign frame_valid = fv_q;
    assign scan_err = err_q;
    assign frame_cnt = fcnt_q;
    assign err_cnt = ecnt_q;
    assign locked = state_q == ST_CAPTURE;
endmodule

// File: tb/tb_dot_scan_rx.sv
// tb_dot_scan_rx: directed scan sequences with a scoreboard checked on every output event
module tb_dot_scan_rx;
    import dot_scan_rx_pkg::*;
    localparam int W = DOT_ROW_W;
    localparam int C = DOT_COLS;

    typedef struct packed {
        logic               is_frame;
        logic [7:0]         cnt;
        logic               lck;
        logic [C-1:0][W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [W-1:0] dot_d;
    logic [C-1:0] dot_scan;
    logic [3:0] rd_col;
    logic [W-1:0] rd_data;
    logic frame_valid, scan_err, locked;
    logic [7:0] frame_cnt, err_cnt;

    exp_t sb[$];
    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] exp_fc = 8'd0;
    logic [7:0] exp_ec = 8'd0;

    always #20 clk = ~clk;

    dot_scan_rx dut (
        .clk         (clk),
        .reset       (reset),
        .dot_d       (dot_d),
        .dot_scan    (dot_scan),
        .rd_col      (rd_col),
        .rd_data     (rd_data),
        .frame_valid (frame_valid),
        .scan_err    (scan_err),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt),
        .locked      (locked)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [C-1:0] sel(input int k);
        logic [C-1:0] p;
        p = '1;
        p[k] = 1'b0;
        return p;
    endfunction

    task automatic drive(input logic [C-1:0] pat, input logic [W-1:0] d);
        dot_scan = pat;
        dot_d = d;
        @(posedge clk);
        #2;
    endtask

    task automatic cols(input logic [W-1:0] base, input int from, input int to);
        for (int k = from; k <= to; k++) drive(sel(k), base + W'(k));
    endtask

    task automatic push_frame(input logic [W-1:0] base);
        exp_t e;
        e = '0;
        exp_fc = exp_fc + 8'd1;
        e.is_frame = 1'b1;
        e.cnt = exp_fc;
        e.lck = 1'b1;
        for (int k = 0; k < C; k++) e.data[k] = base + W'(k);
        sb.push_back(e);
    endtask

    task automatic push_err(input logic lck);
        exp_t e;
        e = '0;
        exp_ec = (exp_ec == 8'hFF) ? exp_ec : exp_ec + 8'd1;
        e.cnt = exp_ec;
        e.lck = lck;
        sb.push_back(e);
    endtask

    task automatic frame(input logic [W-1:0] base);
        push_frame(base);
        cols(base, 0, C - 1);
    endtask

    // monitor: every frame_valid/scan_err pops one expectation and checks counters and the whole read port
    initial begin
        logic [C-1:0][W-1:0] last;
        exp_t e;
        last = '0;
        rd_col = 4'd7;
        forever begin
            @(negedge clk or negedge reset);
            if (reset !== 1'b1) begin
                last = '0;
                continue;
            end
            if (frame_valid || scan_err) begin
                chk("fv_se_exclusive", 32'(frame_valid & scan_err), 32'd0);
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_event: got fv=%0b err=%0b expected no event", frame_valid, scan_err);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", 32'(frame_valid), 32'(e.is_frame));
                    chk(e.is_frame ? "frame_cnt" : "err_cnt", e.is_frame ? 32'(frame_cnt) : 32'(err_cnt), 32'(e.cnt));
                    chk("locked", 32'(locked), 32'(e.lck));
                    if (e.is_frame) last = e.data;
                    for (int k = 0; k <= C; k++) begin
                        rd_col = 4'(k);
                        #1;
                        chk($sformatf("rd_data[%0d]", k), 32'(rd_data), k < C ? 32'(last[k]) : 32'd0);
                    end
                    rd_col = 4'd15;
                    #1;
                    chk("rd_data[15]", 32'(rd_data), 32'd0);
                    rd_col = 4'd7;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        dot_scan = '1;
        dot_d = '0;
        #1;
        chk("rst_fv", 32'(frame_valid), 32'd0);
        chk("rst_err", 32'(scan_err), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
        chk("rst_ecnt", 32'(err_cnt), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_rd7", 32'(rd_data), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        frame(14'h000);
        chk("walk_fv", 32'(frame_valid), 32'd1);
        chk("walk_rd7", 32'(rd_data), 32'd7);
        chk("walk_fcnt", 32'(frame_cnt), 32'd1);
        cols(14'h200, 0, 0);
        chk("fv_fall", 32'(frame_valid), 32'd0);
        cols(14'h200, 1, 3);
        push_err(1'b0);
        drive('1, 14'h3FFF);
        chk("allones_err", 32'(scan_err), 32'd1);
        chk("allones_locked", 32'(locked), 32'd0);
        chk("allones_ecnt", 32'(err_cnt), 32'd1);
        chk("allones_rd7", 32'(rd_data), 32'd7);
        cols(14'h300, 5, 9);
        chk("midstart_locked", 32'(locked), 32'd0);
        chk("midstart_ecnt", 32'(err_cnt), 32'd1);
        chk("midstart_fcnt", 32'(frame_cnt), 32'd1);
        frame(14'h300);
        cols(14'h400, 0, 5);
        push_err(1'b1);
        drive(COL0_PAT, 14'h400);
        chk("resync_err", 32'(scan_err), 32'd1);
        chk("resync_locked", 32'(locked), 32'd1);
        push_frame(14'h400);
        cols(14'h400, 1, 9);
        for (int i = 0; i < 256; i++) frame(W'(i * 16));
        chk("wrap_fcnt", 32'(frame_cnt), 32'd3);
        drive(sel(0), 14'h02A);
        for (int i = 0; i < 300; i++) begin
            push_err(1'b1);
            drive(sel(0), 14'h02A);
        end
        chk("sat_ecnt", 32'(err_cnt), 32'd255);
        push_frame(14'h02A);
        cols(14'h02A, 1, 9);
        cols(14'h600, 0, 3);
        reset = 1'b0;
        #1;
        chk("mid_rst_fv", 32'(frame_valid), 32'd0);
        chk("mid_rst_err", 32'(scan_err), 32'd0);
        chk("mid_rst_fcnt", 32'(frame_cnt), 32'd0);
        chk("mid_rst_ecnt", 32'(err_cnt), 32'd0);
        chk("mid_rst_locked", 32'(locked), 32'd0);
        chk("mid_rst_rd7", 32'(rd_data), 32'd0);
        #3;
        reset = 1'b1;
        exp_fc = 8'd0;
        exp_ec = 8'd0;
        cols(14'h600, 4, 9);
        chk("post_rst_locked", 32'(locked), 32'd0);
        chk("post_rst_fcnt", 32'(frame_cnt), 32'd0);
        frame(14'h700);
        chk("post_rst_commit", 32'(frame_cnt), 32'd1);
        chk("post_rst_rd7", 32'(rd_data), 32'h707);
        @(negedge clk);
        #15;
        reset = 1'b0;
        #5;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
